rl_pair_dispatch_controller: RTL and testbench

Scheduler that sequences one home-cell × neighbor-cell sweep into the filter/LJ force evaluation unit. It reads home particles one at a time and neighbor particles NUM_FILTER at a time from cell memories. Each cycle it issues one broadcast pair group (one home particle, NUM_FILTER neighbors) across the filter lanes. It honours per-lane back pressure and supports a half-shell mode for self-cell sweeps.

---
 rtl/rl_pair_dispatch_controller_pkg.sv | 38 +++
 rtl/rl_pair_dispatch_controller_mask_gen.sv | 24 ++
 rtl/rl_pair_dispatch_controller.sv | 153 +++++++++++++++
 tb/tb_rl_pair_dispatch_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_pair_dispatch_controller_pkg.sv
// Shared widths, FSM encoding and stage-1 bundle for the pair dispatcher.
// start_row() picks the first neighbor row a home particle visits.
package rl_pair_dispatch_controller_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int NUM_FILTER          = 4;
  localparam int LANE_BITS           = $clog2(NUM_FILTER);
  localparam int PARTICLE_ADDR_WIDTH = 7;
  localparam int ROW_ADDR_WIDTH      = PARTICLE_ADDR_WIDTH - LANE_BITS;
  localparam int COUNT_WIDTH         = PARTICLE_ADDR_WIDTH + 1;
  localparam int PAIR_WIDTH          = 2 * PARTICLE_ADDR_WIDTH + 1;
  localparam int LANE_DATA_WIDTH     = NUM_FILTER * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef logic [COUNT_WIDTH-1:0]    count_t;
  typedef logic [ROW_ADDR_WIDTH-1:0] row_t;

  typedef struct packed {
    logic                  valid;
    logic [NUM_FILTER-1:0] mask;
  } issue_t;

  // Self-cell sweeps begin at the row holding particle i+1.
  function automatic row_t start_row(
    input count_t i,
    input logic   self_cell
  );
    count_t n;
    n = i + 1'b1;
    return self_cell ? row_t'(n >> LANE_BITS) : '0;
  endfunction

endpackage

// File: rtl/rl_pair_dispatch_controller_mask_gen.sv
// Lane-valid mask for one broadcast group (home i, neighbor row r).
// A lane is live if its neighbor exists and, in self-cell mode, j > i.
module rl_pair_mask_gen
  import rl_pair_dispatch_controller_pkg::*;
(
  input  logic [COUNT_WIDTH-1:0]    home_idx,
  input  logic [ROW_ADDR_WIDTH-1:0] row,
  input  logic [COUNT_WIDTH-1:0]    neighbor_count,
  input  logic                      self_cell,
  output logic [NUM_FILTER-1:0]     mask
);

  for (genvar k = 0; k < NUM_FILTER; k++) begin : g_lane
    logic [COUNT_WIDTH-1:0] idx;
    logic                   in_cell;
    logic                   above_home;

    assign idx        = {1'b0, row, LANE_BITS'(k)};
    assign in_cell    = idx < neighbor_count;
    assign above_home = idx > home_idx;
    assign mask[k]    = in_cell && (!self_cell || above_home);
  end

endmodule

// File: rtl/rl_pair_dispatch_controller.sv
// Sweeps one home cell against one neighbor cell, issuing one home x
// NUM_FILTER-neighbor group per cycle through a 2-stage read pipeline.
module rl_pair_dispatch_controller
  import rl_pair_dispatch_controller_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           self_cell,
  input  logic [COUNT_WIDTH-1:0]         home_count,
  input  logic [COUNT_WIDTH-1:0]         neighbor_count,
  output logic [PARTICLE_ADDR_WIDTH-1:0] home_rd_addr,
  input  logic [DATA_WIDTH-1:0]          home_rd_x,
  input  logic [DATA_WIDTH-1:0]          home_rd_y,
  input  logic [DATA_WIDTH-1:0]          home_rd_z,
  output logic [ROW_ADDR_WIDTH-1:0]      nb_rd_addr,
  input  logic [LANE_DATA_WIDTH-1:0]     nb_rd_x,
  input  logic [LANE_DATA_WIDTH-1:0]     nb_rd_y,
  input  logic [LANE_DATA_WIDTH-1:0]     nb_rd_z,
  input  logic [NUM_FILTER-1:0]          back_pressure_to_input,
  output logic [NUM_FILTER-1:0]          input_valid,
  output logic [LANE_DATA_WIDTH-1:0]     refx,
  output logic [LANE_DATA_WIDTH-1:0]     refy,
  output logic [LANE_DATA_WIDTH-1:0]     refz,
  output logic [LANE_DATA_WIDTH-1:0]     neighborx,
  output logic [LANE_DATA_WIDTH-1:0]     neighbory,
  output logic [LANE_DATA_WIDTH-1:0]     neighborz,
  output logic                           busy,
  output logic                           done,
  output logic [PAIR_WIDTH-1:0]          pair_count
);

  state_t                state;
  count_t                i_q;
  row_t                  r_q;
  count_t                home_cnt_q;
  count_t                nb_cnt_q;
  logic                  self_q;
  issue_t                s1;

  logic [NUM_FILTER-1:0] mask;
  logic                  stall;
  count_t                nb_last;
  row_t                  last_row;
  count_t                next_i;
  count_t                next_j;
  logic                  next_ok;
  logic                  first_ok;

  assign home_rd_addr = i_q[PARTICLE_ADDR_WIDTH-1:0];
  assign nb_rd_addr   = r_q;

  rl_pair_mask_gen u_mask_gen (
    .home_idx       (i_q),
    .row            (r_q),
    .neighbor_count (nb_cnt_q),
    .self_cell      (self_q),
    .mask           (mask)
  );

  assign stall    = |back_pressure_to_input;
  assign nb_last  = nb_cnt_q - 1'b1;
  assign last_row = row_t'(nb_last >> LANE_BITS);
  assign next_i   = i_q + 1'b1;
  assign next_j   = next_i + 1'b1;

  // A self-cell home with no partner above it is skipped outright.
  assign next_ok  = (next_i < home_cnt_q) &&
                    (!self_q || (next_j < nb_cnt_q));

  assign first_ok = (home_count != '0) &&
                    (neighbor_count != '0) &&
                    (!self_cell || (neighbor_count > count_t'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      i_q         <= '0;
      r_q         <= '0;
      home_cnt_q  <= '0;
      nb_cnt_q    <= '0;
      self_q      <= 1'b0;
      s1          <= '0;
      input_valid <= '0;
      refx        <= '0;
      refy        <= '0;
      refz        <= '0;
      neighborx   <= '0;
      neighbory   <= '0;
      neighborz   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pair_count  <= '0;
    end else begin
      done        <= 1'b0;
      s1.valid    <= 1'b0;
      input_valid <= s1.valid ? s1.mask : '0;

      if (s1.valid) begin
        refx      <= {NUM_FILTER{home_rd_x}};
        refy      <= {NUM_FILTER{home_rd_y}};
        refz      <= {NUM_FILTER{home_rd_z}};
        neighborx <= nb_rd_x;
        neighbory <= nb_rd_y;
        neighborz <= nb_rd_z;
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            home_cnt_q <= home_count;
            nb_cnt_q   <= neighbor_count;
            self_q     <= self_cell;
            pair_count <= '0;
            busy       <= 1'b1;
            i_q        <= '0;
            r_q        <= start_row('0, self_cell);
            state      <= first_ok ? ST_RUN : ST_DRAIN;
          end
        end

        ST_RUN: begin
          if (!stall) begin
            s1.valid   <= 1'b1;
            s1.mask    <= mask;
            pair_count <= pair_count + PAIR_WIDTH'($countones(mask));
            if (r_q == last_row) begin
              if (next_ok) begin
                i_q <= next_i;
                r_q <= start_row(next_i, self_q);
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              r_q <= r_q + 1'b1;
            end
          end
        end

        // Stage 1 always empties into stage 2 on this edge, so done
        // lands in the same cycle as the final group.
        ST_DRAIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rl_pair_dispatch_controller.sv
// Directed bench for the pair dispatcher: group order, masks, timing,
// back pressure, empty cells, mid-sweep reset and ignored restarts.
module tb_rl_pair_dispatch_controller;
  import rl_pair_dispatch_controller_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           start;
  logic                           self_cell;
  logic [COUNT_WIDTH-1:0]         home_count;
  logic [COUNT_WIDTH-1:0]         neighbor_count;
  logic [PARTICLE_ADDR_WIDTH-1:0] home_rd_addr;
  logic [DATA_WIDTH-1:0]          home_rd_x, home_rd_y, home_rd_z;
  logic [ROW_ADDR_WIDTH-1:0]      nb_rd_addr;
  logic [LANE_DATA_WIDTH-1:0]     nb_rd_x, nb_rd_y, nb_rd_z;
  logic [NUM_FILTER-1:0]          back_pressure_to_input;
  logic [NUM_FILTER-1:0]          input_valid;
  logic [LANE_DATA_WIDTH-1:0]     refx, refy, refz;
  logic [LANE_DATA_WIDTH-1:0]     neighborx, neighbory, neighborz;
  logic                           busy, done;
  logic [PAIR_WIDTH-1:0]          pair_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc;
  int done_n;
  int done_cyc;
  int rep_bad;
  logic busy_at_done;

  logic [NUM_FILTER-1:0] em_iv[$];
  logic [31:0]           em_ref[$];
  logic [31:0]           em_nb[$];
  int                    em_cyc[$];
  logic [NUM_FILTER-1:0] exp_iv[$];
  int                    exp_h[$];
  int                    exp_r[$];

  rl_pair_dispatch_controller dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .self_cell              (self_cell),
    .home_count             (home_count),
    .neighbor_count         (neighbor_count),
    .home_rd_addr           (home_rd_addr),
    .home_rd_x              (home_rd_x),
    .home_rd_y              (home_rd_y),
    .home_rd_z              (home_rd_z),
    .nb_rd_addr             (nb_rd_addr),
    .nb_rd_x                (nb_rd_x),
    .nb_rd_y                (nb_rd_y),
    .nb_rd_z                (nb_rd_z),
    .back_pressure_to_input (back_pressure_to_input),
    .input_valid            (input_valid),
    .refx                   (refx),
    .refy                   (refy),
    .refz                   (refz),
    .neighborx              (neighborx),
    .neighbory              (neighbory),
    .neighborz              (neighborz),
    .busy                   (busy),
    .done                   (done),
    .pair_count             (pair_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cell memories with one cycle of read latency; data encodes the index.
  always @(posedge clk) begin
    home_rd_x <= 32'h1000_0000 | 32'(home_rd_addr);
    home_rd_y <= 32'h2000_0000 | 32'(home_rd_addr);
    home_rd_z <= 32'h3000_0000 | 32'(home_rd_addr);
    for (int k = 0; k < NUM_FILTER; k++) begin
      nb_rd_x[k*DATA_WIDTH +: DATA_WIDTH] <= 32'h4000_0000 | (32'(nb_rd_addr) * 4 + k);
      nb_rd_y[k*DATA_WIDTH +: DATA_WIDTH] <= 32'h5000_0000 | (32'(nb_rd_addr) * 4 + k);
      nb_rd_z[k*DATA_WIDTH +: DATA_WIDTH] <= 32'h6000_0000 | (32'(nb_rd_addr) * 4 + k);
    end
  end

  always @(negedge clk) begin
    if (input_valid != '0) begin
      em_iv.push_back(input_valid);
      em_ref.push_back(refx[31:0]);
      em_nb.push_back(neighborx[31:0]);
      em_cyc.push_back(cyc);
      if (refx !== {NUM_FILTER{refx[31:0]}} || refz !== {NUM_FILTER{refz[31:0]}})
        rep_bad++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    em_iv.delete();
    em_ref.delete();
    em_nb.delete();
    em_cyc.delete();
    exp_iv.delete();
    exp_h.delete();
    exp_r.delete();
    done_n = 0;
    done_cyc = 0;
    rep_bad = 0;
    busy_at_done = 1'b1;
  endtask

  task automatic push_exp(input logic [NUM_FILTER-1:0] m, input int h, input int r);
    exp_iv.push_back(m);
    exp_h.push_back(h);
    exp_r.push_back(r);
  endtask

  task automatic start_sweep(input string tag, input int hc, input int nc, input logic sc);
    clear_log();
    home_count = COUNT_WIDTH'(hc);
    neighbor_count = COUNT_WIDTH'(nc);
    self_cell = sc;
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_n == 0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, (done_n != 0), 1);
    repeat (3) step();
  endtask

  task automatic check_groups(input string tag);
    chk({tag, "_ngroups"}, em_iv.size(), exp_iv.size());
    for (int g = 0; g < exp_iv.size() && g < em_iv.size(); g++) begin
      chk($sformatf("%s_mask%0d", tag, g), em_iv[g], exp_iv[g]);
      chk($sformatf("%s_ref%0d", tag, g), em_ref[g], 32'h1000_0000 | exp_h[g]);
      chk($sformatf("%s_nb%0d", tag, g), em_nb[g], 32'h4000_0000 | (exp_r[g] * 4));
    end
    chk({tag, "_ref_repl"}, rep_bad, 0);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  task automatic exp_3x5();
    for (int h = 0; h < 3; h++) begin
      push_exp(4'b1111, h, 0);
      push_exp(4'b0001, h, 1);
    end
  endtask

  initial begin
    int n_in;
    int bp_cyc;

    rst = 1'b1;
    start = 1'b0;
    self_cell = 1'b0;
    home_count = '0;
    neighbor_count = '0;
    back_pressure_to_input = '0;
    clear_log();
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_valid", input_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pair_count, 0);
    chk("rst_haddr", home_rd_addr, 0);
    chk("rst_naddr", nb_rd_addr, 0);
    chk("rst_refx", refx, 0);

    // Plain 3 x 5 sweep.
    start_sweep("s1", 3, 5, 1'b0);
    wait_done("s1");
    exp_3x5();
    check_groups("s1");
    chk("s1_pc", pair_count, 15);
    chk("s1_done_n", done_n, 1);
    chk("s1_done_lat", done_cyc - start_cyc, 8);
    chk("s1_done_last", (em_cyc.size() > 0) ? done_cyc - em_cyc[em_cyc.size()-1] : -1, 0);

    // Self-cell 5 x 5: j > i only, home 4 skipped.
    start_sweep("s2", 5, 5, 1'b1);
    wait_done("s2");
    push_exp(4'b1110, 0, 0);
    push_exp(4'b0001, 0, 1);
    push_exp(4'b1100, 1, 0);
    push_exp(4'b0001, 1, 1);
    push_exp(4'b1000, 2, 0);
    push_exp(4'b0001, 2, 1);
    push_exp(4'b0001, 3, 1);
    check_groups("s2");
    chk("s2_pc", pair_count, 10);
    chk("s2_done_n", done_n, 1);

    // Back pressure on one lane for 5 cycles mid-sweep.
    start_sweep("s3", 3, 5, 1'b0);
    repeat (2) step();
    back_pressure_to_input = 4'b0100;
    bp_cyc = cyc;
    for (int h = 0; h < 5; h++) begin
      chk($sformatf("s3_hold_haddr%0d", h), home_rd_addr, 1);
      chk($sformatf("s3_hold_naddr%0d", h), nb_rd_addr, 0);
      step();
    end
    back_pressure_to_input = '0;
    wait_done("s3");
    n_in = 0;
    foreach (em_cyc[g]) if (em_cyc[g] >= bp_cyc && em_cyc[g] < bp_cyc + 5) n_in++;
    chk("s3_inflight_le2", (n_in <= 2), 1);
    exp_3x5();
    check_groups("s3");
    chk("s3_pc", pair_count, 15);

    // Empty home cell, then empty neighbor cell.
    start_sweep("s4a", 0, 5, 1'b0);
    wait_done("s4a");
    chk("s4a_ngroups", em_iv.size(), 0);
    chk("s4a_done_fast", (done_cyc - start_cyc <= 3), 1);
    chk("s4a_pc", pair_count, 0);
    start_sweep("s4b", 3, 0, 1'b0);
    wait_done("s4b");
    chk("s4b_ngroups", em_iv.size(), 0);
    chk("s4b_done_fast", (done_cyc - start_cyc <= 3), 1);
    chk("s4b_pc", pair_count, 0);

    // Reset in the 4th RUN cycle, then a clean 2 x 4 sweep.
    start_sweep("s5", 3, 5, 1'b0);
    repeat (3) step();
    chk("s5_pre_pc", pair_count, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_rst_valid", input_valid, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_pc", pair_count, 0);
    clear_log();
    repeat (4) step();
    chk("s5_no_partial", em_iv.size(), 0);
    start_sweep("s5b", 2, 4, 1'b0);
    wait_done("s5b");
    push_exp(4'b1111, 0, 0);
    push_exp(4'b1111, 1, 0);
    check_groups("s5b");
    chk("s5b_pc", pair_count, 8);

    // Second start during RUN must be ignored.
    start_sweep("s6", 3, 5, 1'b0);
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("s6");
    repeat (10) step();
    chk("s6_done_n", done_n, 1);
    chk("s6_pc", pair_count, 15);
    exp_3x5();
    check_groups("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
